// File: rtl/buzzer_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_tone_gen
//  Brief    : N_CH independent buzzer channels. Each channel synchronises its
//             trigger pin and then either follows it as a gate (continuous
//             tone while held) or fires a fixed burst of BEEP_COUNT beeps on
//             a rising edge. The tone is a 50% square wave whose half-period
//             is set per channel. A global mute returns every channel to idle.
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_tone_gen #(
    parameter int N_CH       = 2,
    parameter int DIV_W      = 16,
    parameter int TIME_W     = 24,
    parameter int BEEP_COUNT = 3,
    parameter int ON_CYCLES  = 10_000_000,
    parameter int OFF_CYCLES = 10_000_000
) (
    input  logic                    sys_clk,
    input  logic                    reset_rtl_0,
    input  logic [N_CH-1:0]         trig,
    input  logic [N_CH-1:0]         mode,
    input  logic [N_CH*DIV_W-1:0]   half_period,
    input  logic                    mute,
    output logic [N_CH-1:0]         buzzer,
    output logic [N_CH-1:0]         busy,
    output logic                    buzzer_any
);

    // ------------------------------------------------------------------------
    // Channel state encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_TONE      = 2'd1;
    localparam logic [1:0] ST_BURST_ON  = 2'd2;
    localparam logic [1:0] ST_BURST_OFF = 2'd3;

    // Beep counter only has to reach BEEP_COUNT-1.
    localparam int BEEP_W = (BEEP_COUNT > 1) ? $clog2(BEEP_COUNT) : 1;

    // Terminal counts: a phase lasting N clocks ends when the timer shows N-1.
    localparam logic [TIME_W-1:0] ON_LAST   = TIME_W'(ON_CYCLES - 1);
    localparam logic [TIME_W-1:0] OFF_LAST  = TIME_W'(OFF_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_COUNT - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch

            // Trigger synchroniser (s1, s2) and edge-detect history (s3)
            logic              s1_q;
            logic              s2_q;
            logic              s3_q;

            // Channel FSM and its counters
            logic [1:0]        state_q;
            logic [1:0]        state_d;
            logic [DIV_W-1:0]  div_q;
            logic [DIV_W-1:0]  div_d;
            logic              tone_q;
            logic              tone_d;
            logic [TIME_W-1:0] timer_q;
            logic [TIME_W-1:0] timer_d;
            logic [BEEP_W-1:0] beep_q;
            logic [BEEP_W-1:0] beep_d;

            // Registered outputs, computed from the next state so that they
            // change on the same edge as the FSM.
            logic              buzzer_q;
            logic              buzzer_d;
            logic              busy_q;
            logic              busy_d;

            logic [DIV_W-1:0]  w_hp;
            logic              w_rise;
            logic              w_wrap;

            assign w_hp   = half_period[gi*DIV_W +: DIV_W];
            assign w_rise = s2_q & ~s3_q;

            // div >= hp-1 written as div+1 >= hp, one bit wider, so that
            // hp = 0 cannot underflow. A shrinking hp that falls below the
            // current count still wraps on the very next edge.
            assign w_wrap = ({1'b0, div_q} + (DIV_W + 1)'(1)) >= {1'b0, w_hp};

            // Metastability synchroniser plus one history flop for edge detect.
            // Mute deliberately does not touch these so a held gate can resume.
            always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
                if (!reset_rtl_0) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                    s3_q <= 1'b0;
                end else begin
                    s1_q <= trig[gi];
                    s2_q <= s1_q;
                    s3_q <= s2_q;
                end
            end

            // Next-state logic: mode select in IDLE, tone divider, burst timing.
            always_comb begin
                state_d = state_q;
                div_d   = div_q;
                tone_d  = tone_q;
                timer_d = timer_q;
                beep_d  = beep_q;

                if (mute) begin
                    // Global abort wins over any simultaneous gate or rise.
                    state_d = ST_IDLE;
                    div_d   = '0;
                    tone_d  = 1'b0;
                    timer_d = '0;
                    beep_d  = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            // mode is only looked at here; it is ignored once
                            // a tone or burst is under way.
                            if (!mode[gi]) begin
                                if (s2_q) begin
                                    state_d = ST_TONE;
                                    div_d   = '0;
                                    tone_d  = 1'b1;
                                end
                            end else if (w_rise) begin
                                state_d = ST_BURST_ON;
                                div_d   = '0;
                                tone_d  = 1'b1;
                                timer_d = '0;
                                beep_d  = '0;
                            end
                        end

                        ST_TONE: begin
                            if (!s2_q) begin
                                state_d = ST_IDLE;
                                div_d   = '0;
                                tone_d  = 1'b0;
                            end else if (w_wrap) begin
                                div_d  = '0;
                                tone_d = ~tone_q;
                            end else begin
                                div_d = div_q + DIV_W'(1);
                            end
                        end

                        ST_BURST_ON: begin
                            if (timer_q == ON_LAST) begin
                                state_d = ST_BURST_OFF;
                                timer_d = '0;
                                div_d   = '0;
                                tone_d  = 1'b0;
                            end else begin
                                timer_d = timer_q + TIME_W'(1);
                                if (w_wrap) begin
                                    div_d  = '0;
                                    tone_d = ~tone_q;
                                end else begin
                                    div_d = div_q + DIV_W'(1);
                                end
                            end
                        end

                        ST_BURST_OFF: begin
                            if (timer_q == OFF_LAST) begin
                                timer_d = '0;
                                if (beep_q == BEEP_LAST) begin
                                    // Last silence done: burst complete.
                                    state_d = ST_IDLE;
                                    beep_d  = '0;
                                end else begin
                                    // Next beep restarts the tone phase.
                                    state_d = ST_BURST_ON;
                                    beep_d  = beep_q + BEEP_W'(1);
                                    div_d   = '0;
                                    tone_d  = 1'b1;
                                end
                            end else begin
                                timer_d = timer_q + TIME_W'(1);
                            end
                        end

                        default: begin
                            state_d = ST_IDLE;
                            div_d   = '0;
                            tone_d  = 1'b0;
                            timer_d = '0;
                            beep_d  = '0;
                        end
                    endcase
                end

                // Sound only while a tone phase is active, tone is high and
                // the divider is configured (hp = 0 means silent).
                buzzer_d = tone_d & (w_hp != '0) &
                           ((state_d == ST_TONE) || (state_d == ST_BURST_ON));
                busy_d   = (state_d != ST_IDLE);
            end

            // Channel state registers, cleared asynchronously.
            always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
                if (!reset_rtl_0) begin
                    state_q  <= ST_IDLE;
                    div_q    <= '0;
                    tone_q   <= 1'b0;
                    timer_q  <= '0;
                    beep_q   <= '0;
                    buzzer_q <= 1'b0;
                    busy_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    div_q    <= div_d;
                    tone_q   <= tone_d;
                    timer_q  <= timer_d;
                    beep_q   <= beep_d;
                    buzzer_q <= buzzer_d;
                    busy_q   <= busy_d;
                end
            end

            assign buzzer[gi] = buzzer_q;
            assign busy[gi]   = busy_q;
        end
    endgenerate

    // Combined indicator for a single shared sounder.
    assign buzzer_any = |buzzer;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_tone_gen
//  Brief    : Directed self-checking bench for buzzer_tone_gen (2 channels,
//             2 beeps of 20 on / 10 off clocks per burst).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_tone_gen;

    localparam int N_CH  = 2;
    localparam int DIV_W = 16;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH-1:0]       trig;
    logic [N_CH-1:0]       mode;
    logic [N_CH*DIV_W-1:0] half_period;
    logic                  mute;
    logic [N_CH-1:0]       buzzer;
    logic [N_CH-1:0]       busy;
    logic                  buzzer_any;

    int n_cmp = 0;
    int n_err = 0;

    bit eb;
    bit ez;

    buzzer_tone_gen #(
        .N_CH       (N_CH),
        .DIV_W      (DIV_W),
        .TIME_W     (24),
        .BEEP_COUNT (2),
        .ON_CYCLES  (20),
        .OFF_CYCLES (10)
    ) dut (
        .sys_clk     (clk),
        .reset_rtl_0 (rst_n),
        .trig        (trig),
        .mode        (mode),
        .half_period (half_period),
        .mute        (mute),
        .buzzer      (buzzer),
        .busy        (busy),
        .buzzer_any  (buzzer_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Channel 1 burst with hp=3. trig[1] must be raised at the negedge just
    // before the call (or held through reset release). Sample k follows the
    // k-th rising edge; the burst occupies samples 3..62.
    task automatic burst_run(input string name, input int pulse_len, input bit repulse);
        bit xb;
        bit xz;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            xb = (k >= 3 && k <= 62);
            if (k >= 3 && k <= 22)       xz = ((k - 3) % 6) < 3;
            else if (k >= 33 && k <= 52) xz = ((k - 33) % 6) < 3;
            else                         xz = 1'b0;
            check_eq($sformatf("%s busy1 k=%0d", name, k), 32'(busy[1]), 32'(xb));
            check_eq($sformatf("%s buz1 k=%0d", name, k), 32'(buzzer[1]), 32'(xz));
            check_eq($sformatf("%s any k=%0d", name, k), 32'(buzzer_any), 32'(xz));
            if (pulse_len > 0 && k == pulse_len) trig[1] = 1'b0;
            if (repulse && k == 40) trig[1] = 1'b1;
            if (repulse && k == 41) trig[1] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        trig        = '0;
        mode        = '0;
        half_period = '0;
        mute        = 1'b0;

        // ---------------- reset state ----------------
        idle(3);
        check_eq("rst buzzer", 32'(buzzer), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst any", 32'(buzzer_any), 32'd0);
        rst_n = 1'b1;
        idle(3);
        check_eq("post-rst busy", 32'(busy), 32'd0);

        // ---------------- gate mode, ch0, hp=4 ----------------
        mode        = 2'b00;
        half_period = {16'd0, 16'd4};
        trig[0]     = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            eb = (k >= 3 && k <= 32);
            ez = eb && (((k - 3) / 4) % 2 == 0);
            check_eq($sformatf("gate busy0 k=%0d", k), 32'(busy[0]), 32'(eb));
            check_eq($sformatf("gate buz0 k=%0d", k), 32'(buzzer[0]), 32'(ez));
            if (k == 30) trig[0] = 1'b0;
        end
        idle(4);

        // ---------------- burst mode, ch1, hp=3, with ignored re-pulse ----------------
        mode        = 2'b10;
        half_period = {16'd3, 16'd0};
        trig[1]     = 1'b1;
        burst_run("burst", 1, 1'b1);
        idle(4);

        // ---------------- mute during ch1 burst, coincident with ch0 rise ----------------
        mode        = 2'b11;
        half_period = {16'd3, 16'd4};
        trig[1]     = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 10) begin
                check_eq("mute pre busy", 32'(busy), 32'b10);
            end
            if (k >= 11) begin
                check_eq($sformatf("mute busy k=%0d", k), 32'(busy), 32'd0);
                check_eq($sformatf("mute buz k=%0d", k), 32'(buzzer), 32'd0);
            end
            if (k == 1)  trig[1] = 1'b0;
            if (k == 8)  trig[0] = 1'b1;
            if (k == 10) mute = 1'b1;
            if (k == 11) mute = 1'b0;
        end
        trig = '0;
        idle(4);

        // ---------------- gate resumes right after mute release ----------------
        mode        = 2'b00;
        half_period = {16'd0, 16'd4};
        trig[0]     = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check_eq("gmute pre busy0", 32'(busy[0]), 32'd1);
                check_eq("gmute pre buz0", 32'(buzzer[0]), 32'd1);
                mute = 1'b1;
            end else if (k == 6) begin
                check_eq("gmute busy0", 32'(busy[0]), 32'd0);
                check_eq("gmute buz0", 32'(buzzer[0]), 32'd0);
                mute = 1'b0;
            end else if (k == 7) begin
                check_eq("gmute resume busy0", 32'(busy[0]), 32'd1);
                check_eq("gmute resume buz0", 32'(buzzer[0]), 32'd1);
            end
        end
        trig = '0;
        idle(4);

        // ---------------- hp=0 on ch0, hp shrink 10->2 on ch1 ----------------
        mode        = 2'b00;
        half_period = {16'd10, 16'd0};
        trig        = 2'b11;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                check_eq($sformatf("hp0 busy0 k=%0d", k), 32'(busy[0]), 32'd1);
                check_eq($sformatf("hp0 buz0 k=%0d", k), 32'(buzzer[0]), 32'd0);
            end
            if (k >= 3 && k <= 10)
                check_eq($sformatf("shrink buz1 k=%0d", k), 32'(buzzer[1]), 32'd1);
            if (k == 11) check_eq("shrink buz1 k=11", 32'(buzzer[1]), 32'd0);
            if (k == 12) check_eq("shrink buz1 k=12", 32'(buzzer[1]), 32'd0);
            if (k == 13) check_eq("shrink buz1 k=13", 32'(buzzer[1]), 32'd1);
            if (k == 10) half_period = {16'd2, 16'd0};
        end
        trig = '0;
        idle(4);

        // ---------------- async reset mid-burst, trig held through release ----------------
        mode        = 2'b10;
        half_period = {16'd3, 16'd0};
        trig[1]     = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) trig[1] = 1'b0;
        end
        check_eq("rstmid pre busy1", 32'(busy[1]), 32'd1);
        check_eq("rstmid pre buz1", 32'(buzzer[1]), 32'd1);
        trig[1] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid async buzzer", 32'(buzzer), 32'd0);
        check_eq("rstmid async busy", 32'(busy), 32'd0);
        check_eq("rstmid async any", 32'(buzzer_any), 32'd0);
        idle(3);
        check_eq("rstmid held busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        burst_run("rstburst", 0, 1'b0);
        trig = '0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
